timer_periph: RTL
=================

// Module: timer_periph
// PURPOSE
//   Memory-mapped 32-bit timer/compare peripheral on the core data bus, alongside the UART and IO port.
//   It decodes core load/store addresses and returns read data on its own data-bus slot (dataOut/outEn).
//   It counts prescaled clk ticks, flags compare-match and overflow, and raises a level irq.
// PARAMETERS
//   ADDRW      11       bus address width compared against register addresses
//   XLEN       32       data width
//   PSC_W      8        prescaler field width
//   TCR_ADDR   11'h407  control register address
//   TCNT_ADDR  11'h408  counter register address
//   TCMP_ADDR  11'h409  compare register address
//   TSR_ADDR   11'h40A  status register address
// PORTS
//   clk     in   1      system clock; single clock domain
//   rst     in   1      synchronous reset, active-high
//   addr    in   ADDRW  core bus address
//   wrData  in   XLEN   core store data
//   wrEn    in   1      store strobe, 1 cycle
//   rdEn    in   1      peripheral-space load strobe, 1 cycle
//   dataOut out  XLEN   read data; 0 whenever outEn=0
//   outEn   out  1      read data valid
//   irq     out  1      level interrupt
// BEHAVIOUR
//   Reset (rst=1 at posedge): TCR=0, TCNT=0, TCMP=32'hFFFF_FFFF, TSR=0, prescaler count=0.
//     dataOut=0, outEn=0, irq=0.
//   TCR bits: [0] EN, [1] CLR (clear TCNT on match), [2] ONESHOT (clear EN on match), [3] IE.
//     [15:8] PSC. Other bits read as 0.
//   TSR bits: [0] MATCH, [1] OVF. Writing 1 to a bit clears it; writing 0 has no effect.
//   Write: wrEn & addr==REG_ADDR updates that register at the next edge.
//     A write to an unmapped address is ignored.
//   Read: rdEn & addr matches a register -> dataOut=value, outEn=1 on the NEXT cycle, for exactly 1 cycle.
//     A non-matching read leaves outEn=0.
//     Register value is sampled at the rdEn edge, before same-cycle hardware updates.
//   Prescaler: while EN=1, pcnt increments each cycle.
//     When pcnt==PSC, pcnt wraps to 0 and tick=1, so one tick occurs every PSC+1 cycles.
//     PSC=0 gives a tick every cycle.
//     EN=0 holds pcnt at 0. Rewriting PSC clears pcnt.
//   On tick:
//     - TCNT==TCMP: set MATCH. If CLR, TCNT<=0; else TCNT<=TCNT+1. If ONESHOT, EN<=0.
//     - else if TCNT==32'hFFFF_FFFF: TCNT<=0, set OVF.
//     - else TCNT<=TCNT+1.
//   Arithmetic is unsigned modulo 2^32. There is no saturation.
//   Simultaneous events:
//     - A software TCNT write beats a tick increment in the same cycle; the written value is kept.
//     - A hardware MATCH/OVF set beats a same-cycle W1C; the bit stays 1.
//     - A TCR write clearing EN beats ONESHOT; the written value wins.
//   irq = IE & (MATCH|OVF), registered, so it follows the flags by 1 cycle.
//   Reset mid-operation discards any pending read response (outEn=0 next cycle).
// STRUCTURE
//   Shared pkg soc_map_pkg holds:
//     - peripheral addresses (UART 11'h402/403, IO 11'h404-406, timer 11'h407-40A);
//     - TCR/TSR bit-index localparams;
//     - XLEN and ADDRW.
//   One sub-module: timer_prescaler (clk, rst, en, psc, clr -> tick).
//   Register file, compare logic and bus read mux stay in timer_periph.
// TESTING
//   1. Reset, then read each register -> TCR=0, TCNT=0, TCMP=FFFF_FFFF, TSR=0.
//      outEn high exactly 1 cycle after rdEn.
//   2. TCMP=5, TCR=0x0B (EN|CLR|IE, PSC=0) -> MATCH set on the 6th tick and TCNT returns to 0.
//      irq=1 one cycle later; W1C TSR=1 -> irq=0.
//   3. PSC=3, TCMP=2 -> ticks every 4 cycles; MATCH is set 12 cycles after EN.
//   4. TCNT=FFFF_FFFE, EN, PSC=0 -> after 2 ticks TCNT=0 and OVF=1.
//   5. ONESHOT|EN, TCMP=1 -> EN cleared after match and TCNT frozen at 2.
//   6. In the same cycle: tick match plus W1C of MATCH -> MATCH stays 1.
//      In the same cycle: TCNT write plus tick -> the written value holds.

Source files
------------

// File: rtl/soc_map_pkg.sv
// SoC data-bus address map and timer register field layout shared by the
// bus peripherals (UART, IO port, timer).
package soc_map_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ADDRW = 11;
  localparam int unsigned PSC_W = 8;

  localparam logic [ADDRW-1:0] UART_DATA_ADDR = 11'h402;
  localparam logic [ADDRW-1:0] UART_STAT_ADDR = 11'h403;
  localparam logic [ADDRW-1:0] IO_DIR_ADDR    = 11'h404;
  localparam logic [ADDRW-1:0] IO_OUT_ADDR    = 11'h405;
  localparam logic [ADDRW-1:0] IO_IN_ADDR     = 11'h406;
  localparam logic [ADDRW-1:0] TCR_ADDR       = 11'h407;
  localparam logic [ADDRW-1:0] TCNT_ADDR      = 11'h408;
  localparam logic [ADDRW-1:0] TCMP_ADDR      = 11'h409;
  localparam logic [ADDRW-1:0] TSR_ADDR       = 11'h40A;

  localparam int unsigned TCR_EN      = 0;
  localparam int unsigned TCR_CLR     = 1;
  localparam int unsigned TCR_ONESHOT = 2;
  localparam int unsigned TCR_IE      = 3;
  localparam int unsigned TCR_PSC_LSB = 8;

  localparam int unsigned TSR_MATCH = 0;
  localparam int unsigned TSR_OVF   = 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TCR,
    SEL_TCNT,
    SEL_TCMP,
    SEL_TSR
  } tmr_sel_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk into a one-cycle tick every psc+1 cycles while enabled;
// the divider restarts from zero when disabled or explicitly cleared.
module timer_prescaler #(
  parameter int unsigned PSC_W = soc_map_pkg::PSC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             clr,
  output logic             tick
);

  logic [PSC_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick   = en && (pcnt_q == psc);
    pcnt_d = pcnt_q + PSC_W'(1);
    if (!en || clr || tick) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped 32-bit timer with compare match, overflow flag and level irq.
// Read data is returned on the cycle after the load strobe, zero otherwise.
module timer_periph #(
  parameter int unsigned      ADDRW     = soc_map_pkg::ADDRW,
  parameter int unsigned      XLEN      = soc_map_pkg::XLEN,
  parameter int unsigned      PSC_W     = soc_map_pkg::PSC_W,
  parameter logic [ADDRW-1:0] TCR_ADDR  = soc_map_pkg::TCR_ADDR,
  parameter logic [ADDRW-1:0] TCNT_ADDR = soc_map_pkg::TCNT_ADDR,
  parameter logic [ADDRW-1:0] TCMP_ADDR = soc_map_pkg::TCMP_ADDR,
  parameter logic [ADDRW-1:0] TSR_ADDR  = soc_map_pkg::TSR_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic [XLEN-1:0]  wrData,
  input  logic             wrEn,
  input  logic             rdEn,
  output logic [XLEN-1:0]  dataOut,
  output logic             outEn,
  output logic             irq
);
  import soc_map_pkg::*;

  localparam logic [XLEN-1:0] TCR_MASK =
    (XLEN'((1 << PSC_W) - 1) << TCR_PSC_LSB) | XLEN'(4'hF);

  tmr_sel_e        sel;
  logic            wr_tcr, wr_tcnt, wr_tcmp, wr_tsr;
  logic            tick;
  logic [XLEN-1:0] tcr_q, tcr_d;
  logic [XLEN-1:0] tcnt_q, tcnt_d;
  logic [XLEN-1:0] tcmp_q, tcmp_d;
  logic [1:0]      tsr_q, tsr_d;
  logic [1:0]      hw_set, w1c;
  logic [XLEN-1:0] rd_val;
  logic            rd_hit;
  logic [XLEN-1:0] rdata_q;
  logic            oen_q;
  logic            irq_q;

  always_comb begin
    sel = SEL_NONE;
    if (addr == TCR_ADDR) begin
      sel = SEL_TCR;
    end else if (addr == TCNT_ADDR) begin
      sel = SEL_TCNT;
    end else if (addr == TCMP_ADDR) begin
      sel = SEL_TCMP;
    end else if (addr == TSR_ADDR) begin
      sel = SEL_TSR;
    end
  end

  assign wr_tcr  = wrEn && (sel == SEL_TCR);
  assign wr_tcnt = wrEn && (sel == SEL_TCNT);
  assign wr_tcmp = wrEn && (sel == SEL_TCMP);
  assign wr_tsr  = wrEn && (sel == SEL_TSR);

  timer_prescaler #(
    .PSC_W(PSC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (tcr_q[TCR_EN]),
    .psc  (tcr_q[TCR_PSC_LSB +: PSC_W]),
    .clr  (wr_tcr),
    .tick (tick)
  );

  always_comb begin
    tcr_d  = tcr_q;
    tcnt_d = tcnt_q;
    tcmp_d = tcmp_q;
    hw_set = '0;
    if (tick) begin
      if (tcnt_q == tcmp_q) begin
        hw_set[TSR_MATCH] = 1'b1;
        tcnt_d = tcr_q[TCR_CLR] ? '0 : tcnt_q + XLEN'(1);
        if (tcr_q[TCR_ONESHOT]) begin
          tcr_d[TCR_EN] = 1'b0;
        end
      end else if (tcnt_q == '1) begin
        hw_set[TSR_OVF] = 1'b1;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + XLEN'(1);
      end
    end
    // Software writes are applied after the hardware updates so they win,
    // except for flag sets, which are OR-ed in after the W1C.
    if (wr_tcr) begin
      tcr_d = wrData & TCR_MASK;
    end
    if (wr_tcnt) begin
      tcnt_d = wrData;
    end
    if (wr_tcmp) begin
      tcmp_d = wrData;
    end
    w1c   = wr_tsr ? wrData[1:0] : 2'b00;
    tsr_d = (tsr_q & ~w1c) | hw_set;
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_TCR:  rd_val = tcr_q;
      SEL_TCNT: rd_val = tcnt_q;
      SEL_TCMP: rd_val = tcmp_q;
      SEL_TSR:  rd_val = XLEN'(tsr_q);
      default:  rd_val = '0;
    endcase
    rd_hit = rdEn && (sel != SEL_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcr_q   <= '0;
      tcnt_q  <= '0;
      tcmp_q  <= '1;
      tsr_q   <= '0;
      rdata_q <= '0;
      oen_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      tcr_q   <= tcr_d;
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tsr_q   <= tsr_d;
      rdata_q <= rd_hit ? rd_val : '0;
      oen_q   <= rd_hit;
      irq_q   <= tcr_q[TCR_IE] && (|tsr_q);
    end
  end

  assign dataOut = rdata_q;
  assign outEn   = oen_q;
  assign irq     = irq_q;

endmodule
